spi_ram_burst_wrapper: RTL and testbench

- Parametrised successor to the SPI-slave-plus-RAM wrapper. A single serial port (MOSI/MISO/ss_n) fronts an on-chip memory.
- Adds configurable address and data widths, separate write and read pointers, and burst transfers: the pointer auto-increments with wrap-around for as long as ss_n stays low.
- Sits at the top of the SPI subsystem and replaces the fixed 8-bit wrapper.

---
 rtl/spi_ram_pkg.sv | 27 ++
 rtl/spi_ram_burst_wrapper_mem.sv | 31 +++
 rtl/spi_ram_burst_wrapper.sv | 169 ++++++++++++++++
 tb/tb_spi_ram_burst_wrapper.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI-fronted burst RAM.
package spi_ram_pkg;

  localparam int CMD_BITS = 2;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    HOLD,
    WDATA,
    RTURN,
    RDATA
  } state_e;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_ram_burst_wrapper_mem.sv
// Synchronous 1-write / 1-read memory. Contents are deliberately not reset.
module spi_ram_mem #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [DATA_SIZE-1:0] rdata
);

  localparam int MEM_DEPTH = 2**ADDR_SIZE;

  logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

  // Write port: storage array only, no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; data appears the cycle after re.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/spi_ram_burst_wrapper.sv
// SPI slave fronting an on-chip RAM with separate write/read pointers and
// wrap-around burst transfers for as long as ss_n stays low.
//
// Serial handshake: there is no valid/ready pair. ss_n low frames a
// transaction; every rising clk edge with ss_n low transfers exactly one
// MOSI bit in and (in RDATA) one MISO bit out. ss_n high ends the frame.
module spi_ram_burst_wrapper
  import spi_ram_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic MOSI,
  input  logic ss_n,
  output logic MISO,
  output logic frame_err
);

  localparam int MAX_W = max_int(ADDR_SIZE, DATA_SIZE);
  // Only the bits before the current one are stored; the last bit is MOSI.
  localparam int SH_W  = MAX_W - 1;
  localparam int BC_W  = $clog2(MAX_W);
  localparam int IDX_W = $clog2(DATA_SIZE);

  state_e                 state_q, state_d;
  cmd_e                   cmd_q, cmd_next;
  logic [SH_W-1:0]        shift_q;
  logic [BC_W-1:0]        bit_cnt_q;
  logic [ADDR_SIZE-1:0]   wr_ptr_q, rd_ptr_q;

  logic                   addr_done, word_done, rd_advance, abort_err;
  logic                   mem_re;
  logic [ADDR_SIZE-1:0]   mem_raddr;
  logic [DATA_SIZE-1:0]   rd_data;
  logic [ADDR_SIZE-1:0]   addr_word;
  logic [DATA_SIZE-1:0]   data_word;
  logic [IDX_W-1:0]       tx_idx;

  assign addr_word = {shift_q[ADDR_SIZE-2:0], MOSI};
  assign data_word = {shift_q[DATA_SIZE-2:0], MOSI};
  // MSB first: bit 0 of the counter selects the word's top bit.
  assign tx_idx    = IDX_W'(DATA_SIZE - 1) - IDX_W'(bit_cnt_q);

  spi_ram_mem #(
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_SIZE (DATA_SIZE)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (word_done),
    .waddr (wr_ptr_q),
    .wdata (data_word),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (rd_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode plus per-cycle strobes for the datapath.
  always_comb begin
    state_d    = state_q;
    cmd_next   = cmd_e'({shift_q[0], MOSI});
    addr_done  = 1'b0;
    word_done  = 1'b0;
    rd_advance = 1'b0;
    abort_err  = 1'b0;
    mem_re     = 1'b0;
    mem_raddr  = rd_ptr_q;
    if (ss_n) begin
      state_d   = IDLE;
      // Only a partially shifted-in address or data word is an error.
      abort_err = ((state_q == ADDR) || (state_q == WDATA)) && (bit_cnt_q != '0);
    end else begin
      unique case (state_q)
        IDLE:  state_d = CMD;
        CMD: begin
          unique case (cmd_next)
            WR_ADDR, RD_ADDR: state_d = ADDR;
            WR_DATA:          state_d = WDATA;
            default:          state_d = RTURN;
          endcase
        end
        ADDR: begin
          if (bit_cnt_q == BC_W'(ADDR_SIZE - 1)) begin
            addr_done = 1'b1;
            state_d   = HOLD;
          end
        end
        HOLD:  state_d = HOLD;
        WDATA: word_done = (bit_cnt_q == BC_W'(DATA_SIZE - 1));
        RTURN: begin
          mem_re  = 1'b1;
          state_d = RDATA;
        end
        RDATA: begin
          // Prefetch the next word while the LSB goes out, so bursts are gap-free.
          if (bit_cnt_q == BC_W'(DATA_SIZE - 1)) begin
            rd_advance = 1'b1;
            mem_re     = 1'b1;
            mem_raddr  = rd_ptr_q + ADDR_SIZE'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath: shift register, bit counter, pointers, MISO and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q     <= WR_ADDR;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      MISO      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= abort_err;
      MISO      <= 1'b0;
      if (ss_n) begin
        bit_cnt_q <= '0;
      end else begin
        shift_q <= {shift_q[SH_W-2:0], MOSI};
        unique case (state_q)
          CMD: begin
            cmd_q     <= cmd_next;
            bit_cnt_q <= '0;
          end
          ADDR: begin
            if (addr_done) begin
              bit_cnt_q <= '0;
              if (cmd_q == WR_ADDR) wr_ptr_q <= addr_word;
              else                  rd_ptr_q <= addr_word;
            end else begin
              bit_cnt_q <= bit_cnt_q + BC_W'(1);
            end
          end
          WDATA: begin
            if (word_done) begin
              bit_cnt_q <= '0;
              wr_ptr_q  <= wr_ptr_q + ADDR_SIZE'(1);
            end else begin
              bit_cnt_q <= bit_cnt_q + BC_W'(1);
            end
          end
          RDATA: begin
            MISO <= rd_data[tx_idx];
            if (rd_advance) begin
              bit_cnt_q <= '0;
              rd_ptr_q  <= rd_ptr_q + ADDR_SIZE'(1);
            end else begin
              bit_cnt_q <= bit_cnt_q + BC_W'(1);
            end
          end
          default: bit_cnt_q <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_burst_wrapper.sv
// Bench for spi_ram_burst_wrapper: two instances (8/8 and 4/16), a frame-level
// reference model and a scoreboard fed by the drivers, drained by a monitor.
module tb_spi_ram_burst_wrapper;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_v, ss_v, mosi_v, rd_win;
  wire        miso0, miso1, ferr0, ferr1;

  spi_ram_burst_wrapper #(.ADDR_SIZE(8), .DATA_SIZE(8)) dut0 (
    .clk(clk), .rst_n(rst_v[0]), .MOSI(mosi_v[0]), .ss_n(ss_v[0]),
    .MISO(miso0), .frame_err(ferr0));

  spi_ram_burst_wrapper #(.ADDR_SIZE(4), .DATA_SIZE(16)) dut1 (
    .clk(clk), .rst_n(rst_v[1]), .MOSI(mosi_v[1]), .ss_n(ss_v[1]),
    .MISO(miso1), .frame_err(ferr1));

  // ---------------- reference model ----------------
  logic [15:0] mem_m [2][256];
  int          wr_p [2];
  int          rd_p [2];

  function automatic int aw(input int d);    return (d == 0) ? 8 : 4;   endfunction
  function automatic int dw(input int d);    return (d == 0) ? 8 : 16;  endfunction
  function automatic int depth(input int d); return 1 << aw(d);         endfunction
  function automatic logic [15:0] dmask(input int d);
    return (d == 0) ? 16'h00FF : 16'hFFFF;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct { int d; int cyc; } err_t;
  logic [15:0] exp_q[$];
  err_t        err_q[$];
  logic [15:0] wq[$];
  int          compared = 0;
  int          mismatched = 0;
  int          mcyc = 0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    logic [15:0] acc [2];
    int          cnt [2];
    logic        m, f, exp_e;
    acc[0] = '0; acc[1] = '0; cnt[0] = 0; cnt[1] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        mcyc++;
        for (int d = 0; d < 2; d++) begin
          m = (d == 0) ? miso0 : miso1;
          f = (d == 0) ? ferr0 : ferr1;
          exp_e = (err_q.size() > 0) && (err_q[0].d == d) && (err_q[0].cyc == mcyc);
          if (exp_e) void'(err_q.pop_front());
          check($sformatf("frame_err dut%0d", d), {15'd0, f}, {15'd0, exp_e});
          if (rd_win[d]) begin
            acc[d] = {acc[d][14:0], m};
            cnt[d]++;
            if (cnt[d] == dw(d)) begin
              cnt[d] = 0;
              if (exp_q.size() == 0) begin
                check($sformatf("read_word_unexpected dut%0d", d), acc[d] & dmask(d), 16'hxxxx);
              end else begin
                check($sformatf("read_word dut%0d", d), acc[d] & dmask(d), exp_q.pop_front());
              end
            end
          end else begin
            cnt[d] = 0;
            check($sformatf("miso_idle dut%0d", d), {15'd0, m}, 16'd0);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input int d, input logic b);
    @(negedge clk);
    ss_v[d]   = 1'b0;
    mosi_v[d] = b;
    @(posedge clk);
  endtask

  task automatic send_bits(input int d, input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) drive_bit(d, v[i]);
  endtask

  task automatic end_frame(input int d, input bit err);
    err_t e;
    @(negedge clk);
    ss_v[d]   = 1'b1;
    rd_win[d] = 1'b0;
    mosi_v[d] = 1'($urandom_range(0, 1));
    if (err) begin
      e.d   = d;
      e.cyc = mcyc + 1;
      err_q.push_back(e);
    end
    @(posedge clk);
    @(posedge clk);
  endtask

  task automatic addr_frame(input int d, input bit is_rd, input int a);
    send_bits(d, is_rd ? 32'd2 : 32'd0, 2);
    send_bits(d, a, aw(d));
    // Trailing bits land in HOLD and must be ignored.
    repeat ($urandom_range(0, 3)) drive_bit(d, 1'($urandom_range(0, 1)));
    end_frame(d, 1'b0);
    if (is_rd) rd_p[d] = a % depth(d);
    else       wr_p[d] = a % depth(d);
  endtask

  // Writes every word queued in wq as one burst frame.
  task automatic wr_data_frame(input int d);
    logic [15:0] w;
    send_bits(d, 32'd1, 2);
    while (wq.size() > 0) begin
      w = wq.pop_front() & dmask(d);
      send_bits(d, {16'd0, w}, dw(d));
      mem_m[d][wr_p[d]] = w;
      wr_p[d] = (wr_p[d] + 1) % depth(d);
    end
    end_frame(d, 1'b0);
  endtask

  task automatic rd_data_frame(input int d, input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(mem_m[d][rd_p[d]]);
      rd_p[d] = (rd_p[d] + 1) % depth(d);
    end
    send_bits(d, 32'd3, 2);
    drive_bit(d, 1'($urandom_range(0, 1)));
    for (int i = 0; i < n * dw(d); i++) begin
      @(negedge clk);
      ss_v[d]   = 1'b0;
      rd_win[d] = 1'b1;
      mosi_v[d] = 1'($urandom_range(0, 1));
      @(posedge clk);
    end
    end_frame(d, 1'b0);
  endtask

  task automatic abort_data(input int d, input int nbits);
    send_bits(d, 32'd1, 2);
    repeat (nbits) drive_bit(d, 1'($urandom_range(0, 1)));
    end_frame(d, nbits > 0);
  endtask

  task automatic abort_addr(input int d, input bit is_rd, input int nbits);
    send_bits(d, is_rd ? 32'd2 : 32'd0, 2);
    repeat (nbits) drive_bit(d, 1'($urandom_range(0, 1)));
    end_frame(d, nbits > 0);
  endtask

  task automatic reset_dut(input int d);
    @(negedge clk);
    rst_v[d]  = 1'b0;
    ss_v[d]   = 1'b1;
    rd_win[d] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_v[d] = 1'b1;
    wr_p[d]  = 0;
    rd_p[d]  = 0;
    @(posedge clk);
  endtask

  task automatic fill(input int d);
    addr_frame(d, 1'b0, 0);
    for (int i = 0; i < depth(d); i++) wq.push_back(16'($urandom));
    wr_data_frame(d);
  endtask

  task automatic random_ops(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 6))
        0: addr_frame(d, 1'b0, $urandom_range(0, depth(d) - 1));
        1: addr_frame(d, 1'b1, $urandom_range(0, depth(d) - 1));
        2: begin
          repeat ($urandom_range(1, 3)) wq.push_back(16'($urandom));
          wr_data_frame(d);
        end
        3: rd_data_frame(d, $urandom_range(1, 3));
        4: abort_data(d, $urandom_range(0, dw(d) - 1));
        5: abort_addr(d, 1'($urandom_range(0, 1)), $urandom_range(0, aw(d) - 1));
        default: begin
          drive_bit(d, 1'($urandom_range(0, 1)));
          end_frame(d, 1'b0);
        end
      endcase
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_v  = 2'b00;
    ss_v   = 2'b11;
    mosi_v = 2'b00;
    rd_win = 2'b00;
    for (int d = 0; d < 2; d++) begin
      wr_p[d] = 0;
      rd_p[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset miso dut0", {15'd0, miso0}, 16'd0);
    check("reset miso dut1", {15'd0, miso1}, 16'd0);
    check("reset frame_err dut0", {15'd0, ferr0}, 16'd0);
    check("reset frame_err dut1", {15'd0, ferr1}, 16'd0);
    @(negedge clk);
    rst_v  = 2'b11;
    mon_en = 1'b1;
    @(posedge clk);

    // Known contents everywhere so every later read has a defined answer.
    fill(0);
    fill(1);

    // Single write then read.
    addr_frame(0, 1'b0, 'h10);
    wq.push_back(16'h00A5);
    wr_data_frame(0);
    addr_frame(0, 1'b1, 'h10);
    rd_data_frame(0, 1);

    // Burst write across the top of memory, then continue without an address.
    addr_frame(0, 1'b0, 'hFE);
    wq.push_back(16'h0011); wq.push_back(16'h0022); wq.push_back(16'h0033);
    wr_data_frame(0);
    wq.push_back(16'h0044);
    wr_data_frame(0);
    addr_frame(0, 1'b1, 'hFE);
    rd_data_frame(0, 4);

    // Gap-free burst read across the wrap; rd_ptr then continues at 0x01.
    addr_frame(0, 1'b1, 'hFF);
    rd_data_frame(0, 2);
    rd_data_frame(0, 1);

    // Abort after 5 data bits: no write, no pointer move.
    addr_frame(0, 1'b0, 'h30);
    abort_data(0, 5);
    addr_frame(0, 1'b1, 'h30);
    rd_data_frame(0, 1);
    wq.push_back(16'h005A);
    wr_data_frame(0);
    addr_frame(0, 1'b1, 'h30);
    rd_data_frame(0, 1);

    // Reset in the middle of a write frame.
    addr_frame(0, 1'b0, 'h40);
    send_bits(0, 32'd1, 2);
    send_bits(0, 32'h3, 4);
    reset_dut(0);
    addr_frame(0, 1'b0, 'h41);
    wq.push_back(16'h00C3);
    wr_data_frame(0);
    addr_frame(0, 1'b1, 'h40);
    rd_data_frame(0, 2);

    // 4-bit address / 16-bit data instance: wrapping burst of two words.
    addr_frame(1, 1'b0, 'hF);
    wq.push_back(16'hBEEF); wq.push_back(16'hBEEF);
    wr_data_frame(1);
    addr_frame(1, 1'b1, 'hF);
    rd_data_frame(1, 2);

    random_ops(0, 40);
    random_ops(1, 40);

    repeat (5) @(posedge clk);
    #2;
    check("scoreboard drained", 16'(exp_q.size()), 16'd0);
    check("frame_err expectations drained", 16'(err_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
